// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
// Holds the FSM state encoding, the datapath width, the iteration count and a magnitude helper.
package div_pkg;

    localparam int DIV_W    = 32;
    localparam int DIV_ITER = 32;
    localparam int CNT_W    = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Magnitude of a possibly-signed operand; 0x80000000 maps onto itself,
    // which the unsigned datapath then reads as +2^31.
    function automatic logic [DIV_W-1:0] div_mag(input logic [DIV_W-1:0] v,
                                                 input logic               is_signed);
        return (is_signed && v[DIV_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider, purely combinational.
// The quotient register doubles as the dividend shift register: its MSB feeds the remainder.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] i_rem,
    input  logic [DIV_W-1:0] i_quo,
    input  logic [DIV_W-1:0] i_div,
    output logic [DIV_W-1:0] o_rem,
    output logic [DIV_W-1:0] o_quo
);

    logic [DIV_W:0] w_shift;
    logic [DIV_W:0] w_diff;

    assign w_shift = {i_rem, i_quo[DIV_W-1]};
    assign w_diff  = w_shift - {1'b0, i_div};

    // The partial remainder stays below the divisor, so a set top bit of the
    // difference means the trial subtraction borrowed and must be undone.
    always_comb begin
        o_rem = w_shift[DIV_W-1:0];
        o_quo = {i_quo[DIV_W-2:0], 1'b0};
        if (!w_diff[DIV_W]) begin
            o_rem = w_diff[DIV_W-1:0];
            o_quo = {i_quo[DIV_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned 32-bit divider: IDLE -> CALC (32 steps) -> FIX -> DONE.
// Optional macro DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE with dz set.
module div_unit
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] q,
    output logic [DIV_W-1:0] r,
    output logic             dz
);

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_rem;
    logic [DIV_W-1:0] r_quo;
    logic [DIV_W-1:0] r_div;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_busy;
    logic             r_done;
    logic [DIV_W-1:0] r_q;
    logic [DIV_W-1:0] r_r;

    logic [DIV_W-1:0] w_rem_next;
    logic [DIV_W-1:0] w_quo_next;
    logic             w_div_zero;

    div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_next),
        .o_quo (w_quo_next)
    );

`ifdef DIV_ZERO_DETECT_EN
    logic r_dz;
    assign w_div_zero = (divisor == '0);
    assign dz         = r_dz;
`else
    assign w_div_zero = 1'b0;
    assign dz         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            r_dz   <= 1'b0;
`endif
            case (r_state)
                IDLE, DONE: begin
                    if (start && w_div_zero) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_q     <= '1;
                        r_r     <= dividend;
`ifdef DIV_ZERO_DETECT_EN
                        r_dz    <= 1'b1;
`endif
                    end else if (start) begin
                        r_state <= CALC;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= div_mag(dividend, is_signed);
                        r_div   <= div_mag(divisor, is_signed);
                        r_q_neg <= is_signed && (dividend[DIV_W-1] ^ divisor[DIV_W-1]);
                        r_r_neg <= is_signed && dividend[DIV_W-1];
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DIV_ITER - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    // Quotient follows the XOR of signs, remainder follows the dividend.
                    r_q     <= r_q_neg ? (~r_quo + 1'b1) : r_quo;
                    r_r     <= r_r_neg ? (~r_rem + 1'b1) : r_rem;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign q    = r_q;
    assign r    = r_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected quotient/remainder/dz/latency
// pushed at launch and popped at each done pulse.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .r         (r),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: latency counts edges from the start-sampling edge to the edge that sees done.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        e.dz  = 1'b0;
        e.lat = 34;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
`ifdef DIV_ZERO_DETECT_EN
            e.dz  = 1'b1;
            e.lat = 1;
`endif
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end
        return e;
    endfunction

    // Caller must be just after a negedge; the following posedge samples start.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        sb.push_back(model(a, b, s));
    endtask

    task automatic wait_result(input string name, input int poke_k);
        exp_t e;
        int   lat = 0;
        int   busy_cnt = 0;
        bit   found = 0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == poke_k) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom | 32'd1;
            end else if (k == poke_k + 1) begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                lat   = k + 1;
                found = 1;
                break;
            end
        end
        tests_run++;
        if (!found || sb.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s timeout: no done within 100 cycles (queue=%0d)", name, sb.size());
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        $display("[TB] %s: q=%h r=%h dz=%0d lat=%0d busy=%0d", name, q, r, dz, lat, busy_cnt);
        tests_run++;
        if (q !== e.q) begin
            tests_failed++;
            $display("[TB] FAIL %s q: got %h expected %h", name, q, e.q);
        end
        tests_run++;
        if (r !== e.r) begin
            tests_failed++;
            $display("[TB] FAIL %s r: got %h expected %h", name, r, e.r);
        end
        tests_run++;
        if (dz !== e.dz) begin
            tests_failed++;
            $display("[TB] FAIL %s dz: got %0d expected %0d", name, dz, e.dz);
        end
        tests_run++;
        if (lat != e.lat) begin
            tests_failed++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
        end
        tests_run++;
        if (busy_cnt != ((e.lat == 34) ? 33 : 0)) begin
            tests_failed++;
            $display("[TB] FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt,
                     (e.lat == 34) ? 33 : 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'd100;
        divisor = 32'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({busy, done, dz, q, r} !== 67'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset outputs: got busy=%0d done=%0d dz=%0d q=%h r=%h expected all 0",
                     busy, done, dz, q, r);
        end
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset priority: busy got %0d expected 0", busy);
        end
        $display("[TB] reset: busy=%0d done=%0d q=%h r=%h", busy, done, q, r);
    endtask

    task automatic test_unsigned();
        @(negedge clk); launch(32'd100, 32'd7, 1'b0);          wait_result("u100/7", -5);
        @(negedge clk); launch(32'hFFFF_FFFF, 32'd1, 1'b0);    wait_result("uFFFFFFFF/1", -5);
        @(negedge clk); launch(32'd5, 32'd9, 1'b0);            wait_result("u5/9", -5);
    endtask

    task automatic test_signed();
        @(negedge clk); launch(32'hFFFF_FFF9, 32'd2, 1'b1);        wait_result("s-7/2", -5);
        @(negedge clk); launch(32'd7, 32'hFFFF_FFFE, 1'b1);        wait_result("s7/-2", -5);
        @(negedge clk); launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); wait_result("smin/-1", -5);
        @(negedge clk); launch(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1); wait_result("s-100/-7", -5);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            if (b == 32'd0) b = 32'd3;
            @(negedge clk); launch(a, b, i[0]); wait_result("random", -5);
        end
    endtask

    task automatic test_div_zero();
        @(negedge clk); launch(32'h1234_5678, 32'd0, 1'b0); wait_result("u/0", -5);
    endtask

    task automatic test_ignore_start();
        @(negedge clk); launch(32'd1000, 32'd33, 1'b0); wait_result("ignore_start", 9);
    endtask

    task automatic test_back_to_back();
        @(negedge clk); launch(32'd4000, 32'd17, 1'b0); wait_result("b2b_first", -5);
        launch(32'hFFFF_FF00, 32'd16, 1'b1);            wait_result("b2b_second", -5);
    endtask

    task automatic test_mid_reset();
        bit seen = 0;
        @(negedge clk); launch(32'd999, 32'd10, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        tests_run++;
        if ({busy, done, q, r} !== 66'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset outputs: got busy=%0d done=%0d q=%h r=%h expected all 0",
                     busy, done, q, r);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset done: got pulse expected none");
        end
        $display("[TB] mid_reset: busy=%0d q=%h r=%h done_seen=%0d", busy, q, r, seen);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_random();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
